// File: rtl/axis_xgmii_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : eth_xgmii_pkg
// Brief    : XGMII character codes, fixed words, TX framer state type and
//            small helpers shared by the AXI-Stream to XGMII transmit path.
// Revision : 1.0 - initial release
// ============================================================================
package eth_xgmii_pkg;

    localparam logic [7:0] c_CHAR_IDLE     = 8'h07;
    localparam logic [7:0] c_CHAR_START    = 8'hFB;
    localparam logic [7:0] c_CHAR_TERM     = 8'hFD;
    localparam logic [7:0] c_CHAR_ERROR    = 8'hFE;
    localparam logic [7:0] c_CHAR_PREAMBLE = 8'h55;
    localparam logic [7:0] c_CHAR_SFD      = 8'hD5;

    // Start lives on lane 0, six preamble bytes follow, SFD on lane 7.
    localparam logic [63:0] c_WORD_START = {c_CHAR_SFD, {6{c_CHAR_PREAMBLE}}, c_CHAR_START};
    localparam logic [63:0] c_WORD_IDLE  = {8{c_CHAR_IDLE}};
    localparam logic [63:0] c_WORD_ERROR = {8{c_CHAR_ERROR}};
    localparam logic [63:0] c_WORD_TERM  = {{7{c_CHAR_IDLE}}, c_CHAR_TERM};

    // Wide enough for ceil(32/8) = 4 gap words.
    localparam int c_IFG_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_TERM = 3'd2,
        ST_DROP = 3'd3,
        ST_IFG  = 3'd4
    } tx_state_t;

    // Number of valid lanes: run of ones starting at lane 0, anything above
    // the first zero is ignored.
    function automatic logic [3:0] keep_lead_ones(input logic [7:0] keep);
        logic [3:0] w_n;
        logic       w_run;
        w_n   = 4'd0;
        w_run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (w_run && keep[i]) begin
                w_n = w_n + 4'd1;
            end else begin
                w_run = 1'b0;
            end
        end
        return w_n;
    endfunction

    // Idle words still owed after a terminating word that already carried
    // idle_lanes idle characters.
    function automatic logic [2:0] ifg_words(input int ifg_bytes, input int idle_lanes);
        int w_rem;
        w_rem = ifg_bytes - idle_lanes;
        if (w_rem <= 0) begin
            return 3'd0;
        end
        return 3'((w_rem + 7) / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_xgmii_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Interface: axis_xgmii_tx_framer_if
// Brief    : AXI-Stream frame input bus feeding the XGMII transmit framer.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_xgmii_tx_framer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                    input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, input  tuser,
                    output tready);
endinterface
`default_nettype wire

// File: rtl/axis_xgmii_tx_framer_term_encode.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_term_encode
// Brief    : Builds the terminate-lane XGMII word: lanes below n carry data,
//            lane n carries the terminate character, lanes above are idle.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_term_encode
    import eth_xgmii_pkg::*;
(
    input  wire  [63:0] i_data,
    input  wire  [3:0]  i_n,
    output logic [63:0] o_txd,
    output logic [7:0]  o_txc
);

    // Per-lane select between data, terminate and idle fill.
    always_comb begin
        o_txd = c_WORD_IDLE;
        o_txc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < i_n) begin
                o_txd[i*8 +: 8] = i_data[i*8 +: 8];
                o_txc[i]        = 1'b0;
            end else if (4'(i) == i_n) begin
                o_txd[i*8 +: 8] = c_CHAR_TERM;
                o_txc[i]        = 1'b1;
            end else begin
                o_txd[i*8 +: 8] = c_CHAR_IDLE;
                o_txc[i]        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_xgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : axis_xgmii_tx_framer
// Brief    : AXI-Stream to 64-bit XGMII transmit framer. Adds start/preamble/
//            SFD, terminate, idle fill and inter-frame gap; aborts frames on
//            underflow or user error. FCS is expected inside the payload.
// Revision : 1.0 - initial release
// ============================================================================
module axis_xgmii_tx_framer
    import eth_xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int IFG_BYTES  = 12
) (
    input  wire                   tx_clk,
    input  wire                   tx_rst,
    axis_xgmii_tx_framer_if.slave s_axis,
    output logic [DATA_WIDTH-1:0] xgmii_txd,
    output logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic                  tx_start_packet,
    output logic                  tx_underflow
);

    // Gap owed after a TERM word (7 idle lanes) and after an abort (none).
    localparam logic [c_IFG_CNT_W-1:0] c_IFG_TERM  = ifg_words(IFG_BYTES, 7);
    localparam logic [c_IFG_CNT_W-1:0] c_IFG_ABORT = ifg_words(IFG_BYTES, 0);

    tx_state_t              r_state;
    tx_state_t              w_state_d;
    logic [c_IFG_CNT_W-1:0] r_ifg_cnt;
    logic [c_IFG_CNT_W-1:0] w_ifg_cnt_d;

    logic [DATA_WIDTH-1:0]  r_txd;
    logic [CTRL_WIDTH-1:0]  r_txc;
    logic                   r_start;
    logic                   r_uflow;
    logic [DATA_WIDTH-1:0]  w_txd_d;
    logic [CTRL_WIDTH-1:0]  w_txc_d;
    logic                   w_start_d;
    logic                   w_uflow_d;

    logic [3:0]             w_n;
    logic [c_IFG_CNT_W-1:0] w_ifg_lane;
    logic [63:0]            w_term_txd;
    logic [7:0]             w_term_txc;

    assign w_n        = keep_lead_ones(s_axis.tkeep);
    assign w_ifg_lane = ifg_words(IFG_BYTES, 7 - int'(w_n));

    xgmii_term_encode u_term_encode (
        .i_data (s_axis.tdata),
        .i_n    (w_n),
        .o_txd  (w_term_txd),
        .o_txc  (w_term_txc)
    );

    // Ready depends on state only, never on tvalid.
    assign s_axis.tready = (r_state == ST_DATA) || (r_state == ST_DROP);

    assign xgmii_txd       = r_txd;
    assign xgmii_txc       = r_txc;
    assign tx_start_packet = r_start;
    assign tx_underflow    = r_uflow;

    // State register and gap counter.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_state   <= ST_IDLE;
            r_ifg_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_ifg_cnt <= w_ifg_cnt_d;
        end
    end

    // Next state; the gap counter is loaded on the way into IFG.
    always_comb begin
        w_state_d   = r_state;
        w_ifg_cnt_d = r_ifg_cnt;
        case (r_state)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    w_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!s_axis.tvalid) begin
                    w_state_d = ST_DROP;
                end else if (s_axis.tlast) begin
                    if (s_axis.tuser || (w_n == 4'd8)) begin
                        w_state_d = ST_TERM;
                    end else if (w_ifg_lane == '0) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_state_d   = ST_IFG;
                        w_ifg_cnt_d = w_ifg_lane;
                    end
                end
            end
            ST_TERM: begin
                if (c_IFG_TERM == '0) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_state_d   = ST_IFG;
                    w_ifg_cnt_d = c_IFG_TERM;
                end
            end
            ST_DROP: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    if (c_IFG_ABORT == '0) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_state_d   = ST_IFG;
                        w_ifg_cnt_d = c_IFG_ABORT;
                    end
                end
            end
            ST_IFG: begin
                if (r_ifg_cnt <= 3'd1) begin
                    w_state_d   = ST_IDLE;
                    w_ifg_cnt_d = '0;
                end else begin
                    w_ifg_cnt_d = r_ifg_cnt - 3'd1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Word to place on XGMII at the next edge, plus status pulses.
    always_comb begin
        w_txd_d   = c_WORD_IDLE;
        w_txc_d   = '1;
        w_start_d = 1'b0;
        w_uflow_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    w_txd_d   = c_WORD_START;
                    w_txc_d   = 8'h01;
                    w_start_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (!s_axis.tvalid) begin
                    w_txd_d   = c_WORD_ERROR;
                    w_uflow_d = 1'b1;
                end else if (s_axis.tuser) begin
                    w_txd_d = c_WORD_ERROR;
                end else if (s_axis.tlast && (w_n != 4'd8)) begin
                    w_txd_d = w_term_txd;
                    w_txc_d = w_term_txc;
                end else begin
                    w_txd_d = s_axis.tdata;
                    w_txc_d = '0;
                end
            end
            ST_TERM: begin
                w_txd_d = c_WORD_TERM;
            end
            default: begin
                w_txd_d = c_WORD_IDLE;
            end
        endcase
    end

    // Registered XGMII outputs and status pulses.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_txd   <= c_WORD_IDLE;
            r_txc   <= '1;
            r_start <= 1'b0;
            r_uflow <= 1'b0;
        end else begin
            r_txd   <= w_txd_d;
            r_txc   <= w_txc_d;
            r_start <= w_start_d;
            r_uflow <= w_uflow_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_xgmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_xgmii_tx_framer
// Brief    : Randomized self-checking bench for axis_xgmii_tx_framer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_xgmii_tx_framer;

    localparam int          IFG     = 12;
    localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
    localparam logic [63:0] W_START = 64'hD5555555555555FB;
    localparam logic [63:0] W_ERR   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] W_TERM  = 64'h07070707070707FD;

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        bit          sop;
        bit          uf;
        int          idles;
        bit          exact;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        sop;
    logic        uf;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   mon_en = 1'b0;
    int   idle_cnt = 0;

    int          f_len;
    logic [63:0] f_data [8];
    logic [7:0]  f_keep [8];
    bit          f_user [8];
    int          f_uf_pos;
    int          f_uf_gap;
    int          gap_idles = 0;
    bit          gap_exact = 1'b0;

    axis_xgmii_tx_framer_if #(.DATA_WIDTH(64)) s_axis ();

    axis_xgmii_tx_framer #(
        .DATA_WIDTH (64),
        .CTRL_WIDTH (8),
        .IFG_BYTES  (IFG)
    ) dut (
        .tx_clk          (clk),
        .tx_rst          (rst),
        .s_axis          (s_axis),
        .xgmii_txd       (txd),
        .xgmii_txc       (txc),
        .tx_start_packet (sop),
        .tx_underflow    (uf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int ifg_words(input int k);
        int rem;
        rem = IFG - k;
        return (rem <= 0) ? 0 : (rem + 7) / 8;
    endfunction

    function automatic int lead_ones(input logic [7:0] keep);
        int n;
        n = 0;
        while (n < 8 && keep[n]) n++;
        return n;
    endfunction

    task automatic push(input logic [63:0] d, input logic [7:0] c, input bit s, input bit u,
                        input int idl, input bit ex);
        exp_t e;
        e.txd = d; e.txc = c; e.sop = s; e.uf = u; e.idles = idl; e.exact = ex;
        q.push_back(e);
    endtask

    // Expected XGMII words for the frame held in f_*.
    task automatic push_frame();
        logic [63:0] d;
        logic [63:0] w;
        logic [7:0]  c;
        logic [7:0]  lanes[$];
        int          n;
        push(W_START, 8'h01, 1'b1, 1'b0, gap_idles, gap_exact);
        for (int i = 0; i < f_len; i++) begin
            if (i == f_uf_pos) begin
                push(W_ERR, 8'hFF, 1'b0, 1'b1, 0, 1'b1);
                gap_idles = (f_uf_gap - 1) + (f_len - i) + ifg_words(0);
                gap_exact = 1'b1;
                return;
            end
            d = f_data[i];
            if (f_user[i]) begin
                push(W_ERR, 8'hFF, 1'b0, 1'b0, 0, 1'b1);
                if (i == f_len - 1) begin
                    push(W_TERM, 8'hFF, 1'b0, 1'b0, 0, 1'b1);
                    gap_idles = ifg_words(7);
                end
            end else if (i == f_len - 1) begin
                n = lead_ones(f_keep[i]);
                if (n == 8) begin
                    push(d, 8'h00, 1'b0, 1'b0, 0, 1'b1);
                    push(W_TERM, 8'hFF, 1'b0, 1'b0, 0, 1'b1);
                    gap_idles = ifg_words(7);
                end else begin
                    lanes.delete();
                    for (int j = 0; j < n; j++) lanes.push_back(d[8*j +: 8]);
                    lanes.push_back(8'hFD);
                    while (lanes.size() < 8) lanes.push_back(8'h07);
                    for (int j = 0; j < 8; j++) begin
                        w[8*j +: 8] = lanes[j];
                        c[j]        = (j >= n);
                    end
                    push(w, c, 1'b0, 1'b0, 0, 1'b1);
                    gap_idles = ifg_words(7 - n);
                end
            end else begin
                push(d, 8'h00, 1'b0, 1'b0, 0, 1'b1);
            end
        end
        gap_exact = 1'b1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input bit l, input bit u);
        bit r;
        int n;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = s_axis.tready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 64);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
    endtask

    task automatic play_frame();
        for (int i = 0; i < f_len; i++) begin
            if (i == f_uf_pos) begin
                s_axis.tvalid = 1'b0;
                repeat (f_uf_gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word(f_data[i], f_keep[i], (i == f_len - 1), f_user[i]);
        end
    endtask

    task automatic clear_frame(input int len);
        f_len    = len;
        f_uf_pos = -1;
        f_uf_gap = 1;
        for (int i = 0; i < 8; i++) begin
            f_data[i] = {$urandom, $urandom};
            f_keep[i] = 8'hFF;
            f_user[i] = 1'b0;
        end
    endtask

    task automatic rand_frame();
        int sel;
        clear_frame($urandom_range(1, 6));
        for (int i = 0; i < f_len; i++) begin
            f_keep[i] = 8'($urandom);
            f_user[i] = ($urandom_range(0, 9) == 0);
        end
        sel = $urandom_range(0, 3);
        case (sel)
            0:       f_keep[f_len-1] = 8'hFF;
            1:       f_keep[f_len-1] = 8'h00;
            2:       f_keep[f_len-1] = 8'hFF >> $urandom_range(1, 7);
            default: f_keep[f_len-1] = 8'($urandom);
        endcase
        if (f_len >= 2 && $urandom_range(0, 4) == 0) begin
            f_uf_pos = $urandom_range(1, f_len - 1);
            f_uf_gap = $urandom_range(1, 3);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", q.size());
            q.delete();
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Output monitor: idle words are counted, every other word is matched
    // against the next expected entry together with the idle run before it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                idle_cnt = 0;
            end else if (txd === W_IDLE && txc === 8'hFF && sop === 1'b0 && uf === 1'b0) begin
                idle_cnt++;
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h/%h required=idle", txd, txc);
                idle_cnt = 0;
            end else begin
                e = q.pop_front();
                check("txd", txd, e.txd);
                check("txc", {56'd0, txc}, {56'd0, e.txc});
                check("sop_uf", {62'd0, sop, uf}, {62'd0, e.sop, e.uf});
                if (e.exact) begin
                    check("idle_gap", 64'(idle_cnt), 64'(e.idles));
                end else begin
                    checks++;
                    if (idle_cnt < e.idles) begin
                        errors++;
                        $display("FAIL idle_gap_min actual=%0d required>=%0d", idle_cnt, e.idles);
                    end
                end
                idle_cnt = 0;
            end
        end
    end

    initial begin
        int cnt;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", txd, W_IDLE);
        check("rst_txc", {56'd0, txc}, 64'hFF);
        check("rst_tready", {63'd0, s_axis.tready}, 64'd0);
        check("rst_sop", {63'd0, sop}, 64'd0);
        check("rst_uf", {63'd0, uf}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // 2-word frame, last keep 0x0F
        clear_frame(2);
        f_keep[1] = 8'h0F;
        push_frame(); play_frame();
        // full last word, back to back
        clear_frame(2);
        push_frame(); play_frame();
        // underflow on 2nd payload word
        clear_frame(3);
        f_uf_pos = 1;
        f_uf_gap = 1;
        push_frame(); play_frame();
        // user error on middle word
        clear_frame(3);
        f_user[1] = 1'b1;
        f_keep[2] = 8'h3F;
        push_frame(); play_frame();
        // pure terminate
        clear_frame(1);
        f_keep[0] = 8'h00;
        push_frame(); play_frame();

        for (int t = 0; t < 40; t++) begin
            rand_frame();
            if ($urandom_range(0, 3) == 0) begin
                s_axis.tvalid = 1'b0;
                repeat ($urandom_range(1, 5)) begin
                    @(posedge clk);
                    #1;
                end
                gap_exact = 1'b0;
            end
            push_frame();
            play_frame();
        end
        s_axis.tvalid = 1'b0;
        wait_drain();

        // Reset while in DATA, then a new frame right after reset.
        mon_en = 1'b0;
        s_axis.tdata  = 64'h1122334455667788;
        s_axis.tkeep  = 8'hFF;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        s_axis.tvalid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!s_axis.tready && cnt < 40);
        check("pre_reset_ready", {63'd0, s_axis.tready}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_frame(2);
        f_keep[1] = 8'h07;
        gap_idles = 0;
        gap_exact = 1'b1;
        push_frame();
        fork
            play_frame();
            begin
                @(negedge clk);
                check("post_rst_txd", txd, W_IDLE);
                check("post_rst_txc", {56'd0, txc}, 64'hFF);
                check("post_rst_tready", {63'd0, s_axis.tready}, 64'd0);
                check("post_rst_flags", {62'd0, sop, uf}, 64'd0);
                @(posedge clk);
                #1;
                mon_en = 1'b1;
            end
        join
        s_axis.tvalid = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
